// File: rtl/xor_share_arbiter.sv
// xor_share_arbiter: two requesters share one 8-bit XOR unit through a
// round-robin arbiter with a bounded run length (HOLD_MAX) and a one-entry
// result register.
// Optional feature macro: XOR_ARB_STATS_EN adds per-requester accept counters
// (grant0_cnt, grant1_cnt, 16 bits, saturating).

// Shared XOR datapath unit.
module eight_bit_XOR (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] y
);
   assign y = a ^ b;
endmodule

module xor_share_arbiter #(
   parameter int unsigned HOLD_MAX = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic [7:0]  req0_a,
   input  logic [7:0]  req0_b,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [7:0]  req1_a,
   input  logic [7:0]  req1_b,
   output logic        req1_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_id,
   output logic        busy
`ifdef XOR_ARB_STATS_EN
   ,
   output logic [15:0] grant0_cnt,
   output logic [15:0] grant1_cnt
`endif
);

   localparam logic [3:0] HOLD_MAX_C = 4'(HOLD_MAX);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  data_q,  data_d;
   logic        id_q,    id_d;
   logic        ptr_q,   ptr_d;
   logic [3:0]  run_q,   run_d;

   logic        both_valid;
   logic        any_valid;
   logic        gnt_id;
   logic        can_accept;
   logic        accept;
   logic [7:0]  op_a;
   logic [7:0]  op_b;
   logic [7:0]  xor_y;

   // Grant selection and handshake; readies are masked while reset is held
   // because the EMPTY state would otherwise advertise acceptance.
   always_comb begin
      both_valid = req0_valid & req1_valid;
      any_valid  = req0_valid | req1_valid;
      gnt_id     = both_valid ? ptr_q : req1_valid;
      can_accept = (state_q == EMPTY) | out_ready;
      accept     = can_accept & any_valid & rst_n;
      req0_ready = accept & ~gnt_id;
      req1_ready = accept & gnt_id;
      op_a       = gnt_id ? req1_a : req0_a;
      op_b       = gnt_id ? req1_b : req0_b;
   end

   eight_bit_XOR u_xor (
      .a (op_a),
      .b (op_b),
      .y (xor_y)
   );

   // Next-state for result register, priority pointer and run count.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      id_d    = id_q;
      ptr_d   = ptr_q;
      run_d   = run_q;
      if (accept) begin
         state_d = FULL;
         data_d  = xor_y;
         id_d    = gnt_id;
         // id_q always holds the requester of the most recent accept.
         if (gnt_id == id_q) begin
            run_d = (run_q < HOLD_MAX_C) ? run_q + 4'd1 : HOLD_MAX_C;
         end else begin
            run_d = 4'd1;
         end
         if (both_valid && (run_d == HOLD_MAX_C)) begin
            ptr_d = ~gnt_id;
         end
      end else if (out_ready) begin
         state_d = EMPTY;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         data_q  <= '0;
         id_q    <= 1'b0;
         ptr_q   <= 1'b0;
         run_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         run_q   <= run_d;
      end
   end

   // Output mapping.
   always_comb begin
      out_valid = (state_q == FULL);
      out_data  = data_q;
      out_id    = id_q;
      busy      = (state_q == FULL) | req0_valid | req1_valid;
   end

`ifdef XOR_ARB_STATS_EN
   logic [15:0] cnt0_q, cnt0_d;
   logic [15:0] cnt1_q, cnt1_d;

   // Saturating accept counters.
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (req0_ready && (cnt0_q != '1)) cnt0_d = cnt0_q + 16'd1;
      if (req1_ready && (cnt1_q != '1)) cnt1_d = cnt1_q + 16'd1;
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign grant0_cnt = cnt0_q;
   assign grant1_cnt = cnt1_q;
`endif

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Bench for xor_share_arbiter: directed vector table, reset corner cases,
// randomized traffic against a transaction-level model, optional counters.
module tb_xor_share_arbiter;

   localparam int unsigned H = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic [7:0]  req0_a, req0_b, req1_a, req1_b;
   logic        req0_ready, req1_ready;
   logic        out_valid, out_ready;
   logic [7:0]  out_data;
   logic        out_id;
   logic        busy;
`ifdef XOR_ARB_STATS_EN
   logic [15:0] grant0_cnt, grant1_cnt;
`endif

   xor_share_arbiter #(.HOLD_MAX(H)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ready (req1_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_id     (out_id),
      .busy       (busy)
`ifdef XOR_ARB_STATS_EN
      ,
      .grant0_cnt (grant0_cnt),
      .grant1_cnt (grant1_cnt)
`endif
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                        input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                        input logic ordy);
      req0_valid = v0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_a = a1; req1_b = b1;
      out_ready  = ordy;
   endtask

   // Reset is released 1 time unit after a rising edge.
   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   typedef struct {
      logic       v0;
      logic [7:0] a0, b0;
      logic       v1;
      logic [7:0] a1, b1;
      logic       ordy;
      logic       r0, r1, ov;
      logic [7:0] od;
      logic       oid;
   } vec_t;

   vec_t tbl[12];

   // Transaction-level reference state.
   bit          m_full;
   int unsigned m_ptr, m_run, m_last, m_id;
   logic [7:0]  m_data;

   initial begin
      bit          prev_ov;
      bit          v0, v1, ordy, acc;
      logic [7:0]  a0, b0, a1, b1;
      int          g;

      // v0 a0 b0 | v1 a1 b1 | ordy || r0 r1 ov od oid   (HOLD_MAX=2)
      tbl[0]  = '{1'b1, 8'hF0, 8'h3C, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hCC, 1'b0};
      tbl[1]  = '{1'b1, 8'h01, 8'h02, 1'b1, 8'h10, 8'h20, 1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0};
      tbl[2]  = '{1'b1, 8'h04, 8'h00, 1'b1, 8'h11, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1};
      tbl[3]  = '{1'b1, 8'h05, 8'h00, 1'b1, 8'h0F, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1};
      tbl[4]  = '{1'b1, 8'hA5, 8'h0F, 1'b1, 8'h77, 8'h76, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1};
      tbl[5]  = '{1'b1, 8'hA5, 8'h0F, 1'b1, 8'h77, 8'h76, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1};
      tbl[6]  = '{1'b1, 8'hA5, 8'h0F, 1'b1, 8'h77, 8'h76, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1};
      tbl[7]  = '{1'b1, 8'hA5, 8'h0F, 1'b1, 8'h77, 8'h76, 1'b1, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0};
      tbl[8]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      tbl[9]  = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 1'b1, 8'h26, 1'b1};
      tbl[10] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h55, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8'h26, 1'b1};
      tbl[11] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h55, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81, 1'b0};

      // Reset values, with requesters asserting valid during reset.
      rst_n = 1'b0;
      drive(1'b1, 8'h12, 8'h34, 1'b1, 8'h56, 8'h78, 1'b1);
      #3;
      chk("rst_out_valid", 16'(out_valid), 16'h0);
      chk("rst_out_data",  16'(out_data),  16'h00);
      chk("rst_out_id",    16'(out_id),    16'h0);
      chk("rst_req0_ready", 16'(req0_ready), 16'h0);
      chk("rst_req1_ready", 16'(req1_ready), 16'h0);
      do_reset();

      // Directed table.
      prev_ov = 1'b0;
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].ordy);
         #2;
         chk($sformatf("tbl%0d_req0_ready", i), 16'(req0_ready), 16'(tbl[i].r0));
         chk($sformatf("tbl%0d_req1_ready", i), 16'(req1_ready), 16'(tbl[i].r1));
         chk($sformatf("tbl%0d_busy", i), 16'(busy), 16'(prev_ov | tbl[i].v0 | tbl[i].v1));
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_out_valid", i), 16'(out_valid), 16'(tbl[i].ov));
         if (tbl[i].ov) begin
            chk($sformatf("tbl%0d_out_data", i), 16'(out_data), 16'(tbl[i].od));
            chk($sformatf("tbl%0d_out_id", i),   16'(out_id),   16'(tbl[i].oid));
         end
         prev_ov = tbl[i].ov;
      end

      // Asynchronous reset while a result is held.
      drive(1'b1, 8'h11, 8'h22, 1'b1, 8'h33, 8'h44, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 16'(out_valid), 16'h0);
      chk("arst_out_data",  16'(out_data),  16'h00);
      chk("arst_out_id",    16'(out_id),    16'h0);
      chk("arst_req0_ready", 16'(req0_ready), 16'h0);
      chk("arst_req1_ready", 16'(req1_ready), 16'h0);
      drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         chk("post_rst_no_result", 16'(out_valid), 16'h0);
      end
      drive(1'b1, 8'h0A, 8'h05, 1'b1, 8'hC0, 8'h03, 1'b1);
      #2;
      chk("post_rst_tie_req0", 16'(req0_ready), 16'h1);
      chk("post_rst_tie_req1", 16'(req1_ready), 16'h0);
      @(posedge clk); #1;
      chk("post_rst_out_valid", 16'(out_valid), 16'h1);
      chk("post_rst_out_data",  16'(out_data),  16'h0F);
      chk("post_rst_out_id",    16'(out_id),    16'h0);

      // Randomized traffic against the reference model.
      do_reset();
      m_full = 1'b0; m_ptr = 0; m_run = 0; m_last = 0; m_id = 0; m_data = 8'h00;
      for (int n = 0; n < 600; n++) begin
         v0   = ($urandom_range(0, 99) < 70);
         v1   = ($urandom_range(0, 99) < 70);
         ordy = ($urandom_range(0, 99) < 65);
         a0 = 8'($urandom); b0 = 8'($urandom);
         a1 = 8'($urandom); b1 = 8'($urandom);
         drive(v0, a0, b0, v1, a1, b1, ordy);
         if (v0 && v1)  g = int'(m_ptr);
         else if (v0)   g = 0;
         else if (v1)   g = 1;
         else           g = -1;
         acc = (g >= 0) && (!m_full || ordy);
         #2;
         chk("rnd_req0_ready", 16'(req0_ready), 16'(acc && g == 0));
         chk("rnd_req1_ready", 16'(req1_ready), 16'(acc && g == 1));
         chk("rnd_busy", 16'(busy), 16'(m_full || v0 || v1));
         @(posedge clk); #1;
         if (acc) begin
            if (int'(m_last) == g) m_run = (m_run < H) ? m_run + 1 : H;
            else                   m_run = 1;
            if (v0 && v1 && m_run == H) m_ptr = 1 - m_ptr;
            m_last = g;
            m_id   = g;
            m_full = 1'b1;
            m_data = (g == 1) ? (a1 ^ b1) : (a0 ^ b0);
         end else if (ordy) begin
            m_full = 1'b0;
         end
         chk("rnd_out_valid", 16'(out_valid), 16'(m_full));
         if (m_full) begin
            chk("rnd_out_data", 16'(out_data), 16'(m_data));
            chk("rnd_out_id",   16'(out_id),   16'(m_id));
         end
      end

`ifdef XOR_ARB_STATS_EN
      do_reset();
      chk("cnt_rst_g0", grant0_cnt, 16'h0000);
      chk("cnt_rst_g1", grant1_cnt, 16'h0000);
      drive(1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 8'h02, 1'b1);
      repeat (5) @(posedge clk);
      #1 drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
      @(posedge clk); #1;
      chk("cnt_g1_five", grant1_cnt, 16'd5);
      chk("cnt_g0_zero", grant0_cnt, 16'd0);
      drive(1'b1, 8'h01, 8'h02, 1'b0, 8'h00, 8'h00, 1'b1);
      repeat (65540) @(posedge clk);
      #1;
      chk("cnt_g0_sat", grant0_cnt, 16'hFFFF);
      chk("cnt_g1_hold", grant1_cnt, 16'd5);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
